int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
Programmable vectored interrupt controller between the peripheral IRQ lines (timer, UART, user keys, ...) and the CPU's external-interrupt input.
- Latches level- or edge-mode requests per source, applies a mask, and resolves fixed priority with in-service nesting.
- Presents one `irq` line plus the winning source index.
- Mapped as one more bridge device: word-addressed register window, synchronous writes, combinational reads.

Parameters:
- N_SRC, 6, number of interrupt sources (max 8); source 0 highest priority.
- MASK_RST, 0, reset value of the MASK register (N_SRC bits).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- we  in  1  register write strobe (bridge hit & PrWe)
- rd_en  in  1  register read strobe; only used for read side effects
- addr  in  3  word offset, PrAddr[4:2]
- wdata  in  32  write data
- rdata  out  32  read data, combinational from addr and current state
- src_irq  in  N_SRC  raw device interrupt lines, synchronous to clk
- irq  out  1  interrupt request to CPU
- irq_id  out  3  index of the highest-priority eligible source; 0 when irq=0

Behaviour:
- Registers (offset: name, access):
  - 0 CTRL RW: bit0 = global enable GEN; bits[8+N_SRC-1:8] = EDGE mode per source (1=rising edge, 0=level).
  - 1 MASK RW: bits[N_SRC-1:0], 1 = source enabled.
  - 2 PEND R/W1C: pending bits. Writing 1 clears edge-mode bits; level-mode bits ignore writes.
  - 3 INSV RO: in-service bits.
  - 4 VEC RO with side effect: {irq, 28'b0, irq_id}.
  - 5 EOI WO: any write clears the highest-priority set INSV bit.
  - 6,7 reserved: reads return 0, writes ignored. Unused high bits read 0.
- Reset (async, reset=0): CTRL=0, MASK=MASK_RST, PEND=0, INSV=0, edge-history=0. Therefore irq=0, irq_id=0, and rdata is the function of the reset state. Assertion mid-operation discards all pending and in-service state immediately.
- Pending update, every clock:
  - Level source: PEND[i] <= src_irq[i].
  - Edge source: PEND[i] set when src_irq[i] & ~prev[i]; prev[i] <= src_irq[i] always.
- Latency: a source change is visible in PEND and irq one clock after the edge that samples it.
- Eligibility:
  - elig = PEND & MASK & GEN.
  - Source i is eligible only if no INSV bit j ≤ i is set (strictly higher priority than any in-service source).
  - irq = |eligible; irq_id = lowest eligible index. Both combinational from registers.
- Acknowledge: rd_en & addr==4 & irq at a clock edge:
  - INSV[irq_id] <= 1.
  - If that source is edge-mode, PEND[irq_id] <= 0.
  - rdata in that cycle shows the pre-acknowledge value.
  - VEC read with irq=0: returns 0, no state change (spurious read).
- EOI with INSV=0: no-op. EOI clears exactly one bit per write.
- Simultaneous events on the same edge-mode bit:
  - New edge and W1C: set wins.
  - New edge and acknowledge: INSV set, PEND stays 1 (second request kept).
- Clearing GEN or MASK bits does not alter PEND or INSV; it only gates irq.
- Changing EDGE for a source clears that source's PEND bit on the same edge.
- Nesting depth is bounded by N_SRC; no counter overflow possible.
- Reads other than VEC have no side effects; rd_en without addr==4 is ignored.

Decomposition:
- Shared package holds: register offsets (CTRL=0, MASK=1, PEND=2, INSV=3, VEC=4, EOI=5), CTRL field positions (GEN bit 0, EDGE base 8), N_SRC maximum = 8.
- One natural sub-module: prio_enc, an N_SRC-bit lowest-index-first priority encoder with valid output. It is instanced twice: once for the eligible vector (irq_id) and once for INSV (the EOI target and the nesting threshold).

Test Plan:
- Reset with src_irq=6'h3F, CTRL=0 → irq=0, PEND reads 0x3F after 1 clock, VEC reads 0; assert reset mid-run → all regs return to reset values that cycle.
- CTRL=0x0101 (GEN, src0 edge), MASK=0x01, pulse src0 one cycle → irq=1 next clock, VEC reads 0x80000000; after read PEND=0, INSV=0x01, irq=0; EOI write → INSV=0.
- MASK=0x3F, GEN=1, level src2 and src4 high → irq_id=2; VEC read → INSV=0x04, irq=0 (src4 lower priority); raise src1 → irq=1, irq_id=1 (nested); EOI → INSV=0x04; EOI → INSV=0, irq_id=4.
- Edge src3: new rising edge on the same clock as PEND W1C of bit 3 → PEND[3]=1; on the same clock as its VEC acknowledge → INSV[3]=1 and PEND[3]=1.
- Write MASK=0 while PEND=0x10 → irq=0, PEND unchanged; restore MASK=0x10 → irq=1, irq_id=4. EOI with INSV=0 and writes to offsets 6/7 → no register changes; reads of 6/7 return 0.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the vectored interrupt controller: register map,
// CTRL field positions and the architectural source limit.
package int_ctrl_pkg;

    localparam int N_SRC_MAX      = 8;
    localparam int IDX_W          = 3;
    localparam int REG_ADDR_W     = 3;
    localparam int DATA_W         = 32;

    localparam int CTRL_GEN_BIT   = 0;
    localparam int CTRL_EDGE_BASE = 8;

    typedef enum logic [REG_ADDR_W-1:0] {
        REG_CTRL = 3'd0,
        REG_MASK = 3'd1,
        REG_PEND = 3'd2,
        REG_INSV = 3'd3,
        REG_VEC  = 3'd4,
        REG_EOI  = 3'd5,
        REG_RSV6 = 3'd6,
        REG_RSV7 = 3'd7
    } regAddr_e;

endpackage

// File: rtl/int_ctrl_if.sv
// Register-window bus between the bridge (master) and the interrupt
// controller (slave). Writes are synchronous, reads are combinational.
interface int_ctrl_if;
    import int_ctrl_pkg::*;

    logic                  we;
    logic                  rd_en;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output we,
        output rd_en,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  we,
        input  rd_en,
        input  addr,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder. idx_o is 0 whenever nothing is
// requested, so downstream logic can use it directly as a "no source" id.
module prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Programmable vectored interrupt controller. Per-source level/edge capture,
// mask and global enable, fixed priority (source 0 highest) with in-service
// nesting: a source may only interrupt when it outranks every in-service one.
// N_SRC must lie in 1..8.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int               N_SRC    = 6,
    parameter logic [N_SRC-1:0] MASK_RST = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    int_ctrl_if.slave        bus,
    input  logic [N_SRC-1:0] src_irq_i,
    output logic             irq_o,
    output logic [IDX_W-1:0] irq_id_o
);

    localparam logic [N_SRC-1:0] ONE_BIT = N_SRC'(1);

    logic             gen_q, gen_d;
    logic [N_SRC-1:0] edgeMode_q, edgeMode_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] inSrv_q, inSrv_d;
    logic [N_SRC-1:0] prevSrc_q;

    logic             wrCtrl, wrMask, wrPend, wrEoi, ackVec;
    logic [N_SRC-1:0] edgeChange, srcRise, pendClr;
    logic [N_SRC-1:0] ackOneHot, eoiOneHot;
    logic [N_SRC-1:0] allowMask, eligible;
    logic             eligValid, insvValid;
    logic [IDX_W-1:0] eligIdx, insvIdx;
    logic [DATA_W-1:0] rdataD;
    logic             unusedWdata;

    assign unusedWdata = ^bus.wdata;

    // Winning request among eligible sources
    prio_enc #(.WIDTH(N_SRC)) u_elig_enc (
        .req_i   (eligible),
        .valid_o (eligValid),
        .idx_o   (eligIdx)
    );

    // Highest-priority in-service source: EOI target and nesting threshold
    prio_enc #(.WIDTH(N_SRC)) u_insv_enc (
        .req_i   (inSrv_q),
        .valid_o (insvValid),
        .idx_o   (insvIdx)
    );

    // Only sources strictly above the highest in-service one may interrupt
    always_comb begin
        allowMask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            allowMask[i] = !insvValid || (IDX_W'(i) < insvIdx);
        end
    end

    assign eligible = pend_q & mask_q & {N_SRC{gen_q}} & allowMask;
    assign irq_o    = eligValid;
    assign irq_id_o = eligIdx;

    // Bus strobe decode; a VEC read only acknowledges when an irq is shown
    always_comb begin
        wrCtrl = bus.we && (regAddr_e'(bus.addr) == REG_CTRL);
        wrMask = bus.we && (regAddr_e'(bus.addr) == REG_MASK);
        wrPend = bus.we && (regAddr_e'(bus.addr) == REG_PEND);
        wrEoi  = bus.we && (regAddr_e'(bus.addr) == REG_EOI);
        ackVec = bus.rd_en && (regAddr_e'(bus.addr) == REG_VEC) && irq_o;
    end

    // Control, mask and mode updates plus the one-hot acknowledge/EOI vectors
    always_comb begin
        gen_d      = wrCtrl ? bus.wdata[CTRL_GEN_BIT] : gen_q;
        edgeMode_d = wrCtrl ? bus.wdata[CTRL_EDGE_BASE +: N_SRC] : edgeMode_q;
        mask_d     = wrMask ? bus.wdata[N_SRC-1:0] : mask_q;
        edgeChange = edgeMode_d ^ edgeMode_q;
        srcRise    = src_irq_i & ~prevSrc_q;
        ackOneHot  = ackVec ? (ONE_BIT << eligIdx) : '0;
        eoiOneHot  = (wrEoi && insvValid) ? (ONE_BIT << insvIdx) : '0;
        pendClr    = (wrPend ? bus.wdata[N_SRC-1:0] : '0) | ackOneHot;
        inSrv_d    = (inSrv_q & ~eoiOneHot) | ackOneHot;
    end

    // Pending capture: mode change clears, level follows the line, new edge beats any clear
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (edgeChange[i]) begin
                pend_d[i] = 1'b0;
            end else if (!edgeMode_q[i]) begin
                pend_d[i] = src_irq_i[i];
            end else if (srcRise[i]) begin
                pend_d[i] = 1'b1;
            end else if (pendClr[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    // Register state; reset drops all pending and in-service requests at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gen_q      <= 1'b0;
            edgeMode_q <= '0;
            mask_q     <= MASK_RST;
            pend_q     <= '0;
            inSrv_q    <= '0;
            prevSrc_q  <= '0;
        end else begin
            gen_q      <= gen_d;
            edgeMode_q <= edgeMode_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            inSrv_q    <= inSrv_d;
            prevSrc_q  <= src_irq_i;
        end
    end

    // Combinational read mux; write-only and reserved offsets read as zero
    always_comb begin
        rdataD = '0;
        case (regAddr_e'(bus.addr))
            REG_CTRL: begin
                rdataD[CTRL_GEN_BIT]            = gen_q;
                rdataD[CTRL_EDGE_BASE +: N_SRC] = edgeMode_q;
            end
            REG_MASK: rdataD[N_SRC-1:0] = mask_q;
            REG_PEND: rdataD[N_SRC-1:0] = pend_q;
            REG_INSV: rdataD[N_SRC-1:0] = inSrv_q;
            REG_VEC:  rdataD = {irq_o, 28'b0, irq_id_o};
            default:  rdataD = '0;
        endcase
    end

    assign bus.rdata = rdataD;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed testbench for int_ctrl. Inputs change on the falling clock edge
// and outputs are sampled 1 ns after a falling edge, away from the rising
// edge that updates the controller.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [5:0] srcIrq;
    logic       irq;
    logic [2:0] irqId;
    logic [31:0] rd;
    int compares;
    int mismatches;

    int_ctrl_if bus ();

    int_ctrl #(.N_SRC(6), .MASK_RST(6'h00)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus),
        .src_irq_i (srcIrq),
        .irq_o     (irq),
        .irq_id_o  (irqId)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one register write across a single rising edge
    task automatic regWrite(input logic [2:0] a, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.rd_en = 1'b0;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.we    = 1'b0;
        bus.wdata = '0;
    endtask

    // Sample a register (optionally with rd_en) then let one clock pass
    task automatic regRead(input logic [2:0] a, input logic rdEn, output logic [31:0] d);
        bus.we    = 1'b0;
        bus.rd_en = rdEn;
        bus.addr  = a;
        #1 d = bus.rdata;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        srcIrq = 6'h3F;
        @(negedge clk);
        #1;
        if (irq !== 1'b0) begin $display("[TB] FAIL rst_irq: got %0b want 0", irq); mismatches++; end
        compares++;
        if (irqId !== 3'd0) begin $display("[TB] FAIL rst_irqid: got %0d want 0", irqId); mismatches++; end
        compares++;
        regRead(REG_CTRL, 1'b0, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL rst_ctrl: got %h want 0", rd); mismatches++; end
        compares++;
        regRead(REG_PEND, 1'b0, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL rst_pend: got %h want 0", rd); mismatches++; end
        compares++;
        rst_n = 1'b1;
        regRead(REG_PEND, 1'b0, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL rst_pend_latency: got %h want 0", rd); mismatches++; end
        compares++;
        regRead(REG_PEND, 1'b0, rd);
        if (rd !== 32'h3F) begin $display("[TB] FAIL rst_pend_level: got %h want 3f", rd); mismatches++; end
        compares++;
        if (irq !== 1'b0) begin $display("[TB] FAIL rst_irq_gen0: got %0b want 0", irq); mismatches++; end
        compares++;
        regRead(REG_VEC, 1'b1, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL spurious_vec: got %h want 0", rd); mismatches++; end
        compares++;
        regRead(REG_INSV, 1'b0, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL spurious_insv: got %h want 0", rd); mismatches++; end
        compares++;
        srcIrq = 6'h00;
        @(negedge clk);
    endtask

    task automatic test_edge_basic;
        regWrite(REG_CTRL, 32'h0000_0101);
        regWrite(REG_MASK, 32'h0000_0001);
        srcIrq = 6'h01;
        @(negedge clk);
        srcIrq = 6'h00;
        #1;
        if (irq !== 1'b1 || irqId !== 3'd0) begin
            $display("[TB] FAIL edge_irq: got irq=%0b id=%0d want irq=1 id=0", irq, irqId); mismatches++;
        end
        compares++;
        regRead(REG_VEC, 1'b1, rd);
        if (rd !== 32'h8000_0000) begin $display("[TB] FAIL edge_vec: got %h want 80000000", rd); mismatches++; end
        compares++;
        regRead(REG_PEND, 1'b0, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL edge_pend_ack: got %h want 0", rd); mismatches++; end
        compares++;
        regRead(REG_INSV, 1'b0, rd);
        if (rd !== 32'h1) begin $display("[TB] FAIL edge_insv: got %h want 1", rd); mismatches++; end
        compares++;
        if (irq !== 1'b0) begin $display("[TB] FAIL edge_irq_after: got %0b want 0", irq); mismatches++; end
        compares++;
        regWrite(REG_EOI, 32'h0);
        regRead(REG_INSV, 1'b0, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL edge_eoi: got %h want 0", rd); mismatches++; end
        compares++;
    endtask

    task automatic test_nesting;
        regWrite(REG_CTRL, 32'h0000_0001);
        regWrite(REG_MASK, 32'h0000_003F);
        srcIrq = 6'h14;
        @(negedge clk);
        #1;
        if (irq !== 1'b1 || irqId !== 3'd2) begin
            $display("[TB] FAIL nest_first: got irq=%0b id=%0d want irq=1 id=2", irq, irqId); mismatches++;
        end
        compares++;
        regRead(REG_VEC, 1'b1, rd);
        if (rd !== 32'h8000_0002) begin $display("[TB] FAIL nest_vec2: got %h want 80000002", rd); mismatches++; end
        compares++;
        if (irq !== 1'b0) begin $display("[TB] FAIL nest_block4: got irq=%0b want 0", irq); mismatches++; end
        compares++;
        srcIrq = 6'h16;
        @(negedge clk);
        #1;
        if (irq !== 1'b1 || irqId !== 3'd1) begin
            $display("[TB] FAIL nest_src1: got irq=%0b id=%0d want irq=1 id=1", irq, irqId); mismatches++;
        end
        compares++;
        regRead(REG_VEC, 1'b1, rd);
        if (rd !== 32'h8000_0001) begin $display("[TB] FAIL nest_vec1: got %h want 80000001", rd); mismatches++; end
        compares++;
        srcIrq = 6'h14;
        regRead(REG_INSV, 1'b0, rd);
        if (rd !== 32'h6) begin $display("[TB] FAIL nest_insv2: got %h want 6", rd); mismatches++; end
        compares++;
        regWrite(REG_EOI, 32'h0);
        regRead(REG_INSV, 1'b0, rd);
        if (rd !== 32'h4) begin $display("[TB] FAIL nest_eoi1: got %h want 4", rd); mismatches++; end
        compares++;
        if (irq !== 1'b0) begin $display("[TB] FAIL nest_still_blocked: got %0b want 0", irq); mismatches++; end
        compares++;
        srcIrq = 6'h10;
        regWrite(REG_EOI, 32'h0);
        #1;
        if (irq !== 1'b1 || irqId !== 3'd4) begin
            $display("[TB] FAIL nest_eoi2_irq: got irq=%0b id=%0d want irq=1 id=4", irq, irqId); mismatches++;
        end
        compares++;
        regRead(REG_INSV, 1'b0, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL nest_eoi2_insv: got %h want 0", rd); mismatches++; end
        compares++;
    endtask

    task automatic test_mask_gating;
        regWrite(REG_MASK, 32'h0);
        #1;
        if (irq !== 1'b0 || irqId !== 3'd0) begin
            $display("[TB] FAIL mask0_irq: got irq=%0b id=%0d want irq=0 id=0", irq, irqId); mismatches++;
        end
        compares++;
        regRead(REG_PEND, 1'b0, rd);
        if (rd !== 32'h10) begin $display("[TB] FAIL mask0_pend: got %h want 10", rd); mismatches++; end
        compares++;
        regWrite(REG_MASK, 32'h10);
        #1;
        if (irq !== 1'b1 || irqId !== 3'd4) begin
            $display("[TB] FAIL mask_restore: got irq=%0b id=%0d want irq=1 id=4", irq, irqId); mismatches++;
        end
        compares++;
        regWrite(REG_CTRL, 32'h0);
        #1;
        if (irq !== 1'b0) begin $display("[TB] FAIL gen0_irq: got %0b want 0", irq); mismatches++; end
        compares++;
        regRead(REG_PEND, 1'b0, rd);
        if (rd !== 32'h10) begin $display("[TB] FAIL gen0_pend: got %h want 10", rd); mismatches++; end
        compares++;
        regWrite(REG_CTRL, 32'h1);
    endtask

    task automatic test_eoi_reserved;
        regWrite(REG_EOI, 32'hFFFF_FFFF);
        regWrite(REG_RSV6, 32'hFFFF_FFFF);
        regWrite(REG_RSV7, 32'hFFFF_FFFF);
        regRead(REG_CTRL, 1'b0, rd);
        if (rd !== 32'h1) begin $display("[TB] FAIL rsv_ctrl: got %h want 1", rd); mismatches++; end
        compares++;
        regRead(REG_MASK, 1'b0, rd);
        if (rd !== 32'h10) begin $display("[TB] FAIL rsv_mask: got %h want 10", rd); mismatches++; end
        compares++;
        regRead(REG_PEND, 1'b0, rd);
        if (rd !== 32'h10) begin $display("[TB] FAIL rsv_pend: got %h want 10", rd); mismatches++; end
        compares++;
        regRead(REG_INSV, 1'b0, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL rsv_insv: got %h want 0", rd); mismatches++; end
        compares++;
        regRead(REG_RSV6, 1'b1, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL rsv6_read: got %h want 0", rd); mismatches++; end
        compares++;
        regRead(REG_RSV7, 1'b0, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL rsv7_read: got %h want 0", rd); mismatches++; end
        compares++;
        regRead(REG_EOI, 1'b0, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL eoi_read: got %h want 0", rd); mismatches++; end
        compares++;
    endtask

    task automatic test_edge_collisions;
        srcIrq = 6'h00;
        regWrite(REG_MASK, 32'h08);
        regWrite(REG_CTRL, 32'h0000_0801);
        srcIrq = 6'h08;
        @(negedge clk);
        #1;
        if (irq !== 1'b1 || irqId !== 3'd3) begin
            $display("[TB] FAIL coll_edge3: got irq=%0b id=%0d want irq=1 id=3", irq, irqId); mismatches++;
        end
        compares++;
        regWrite(REG_PEND, 32'h08);
        regRead(REG_PEND, 1'b0, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL coll_w1c: got %h want 0", rd); mismatches++; end
        compares++;
        srcIrq = 6'h00;
        @(negedge clk);
        srcIrq = 6'h08;
        regWrite(REG_PEND, 32'h08);
        regRead(REG_PEND, 1'b0, rd);
        if (rd !== 32'h08) begin $display("[TB] FAIL coll_set_wins: got %h want 8", rd); mismatches++; end
        compares++;
        srcIrq = 6'h00;
        @(negedge clk);
        srcIrq = 6'h08;
        regRead(REG_VEC, 1'b1, rd);
        if (rd !== 32'h8000_0003) begin $display("[TB] FAIL coll_vec3: got %h want 80000003", rd); mismatches++; end
        compares++;
        regRead(REG_INSV, 1'b0, rd);
        if (rd !== 32'h08) begin $display("[TB] FAIL coll_ack_insv: got %h want 8", rd); mismatches++; end
        compares++;
        regRead(REG_PEND, 1'b0, rd);
        if (rd !== 32'h08) begin $display("[TB] FAIL coll_ack_pend: got %h want 8", rd); mismatches++; end
        compares++;
        if (irq !== 1'b0) begin $display("[TB] FAIL coll_ack_irq: got %0b want 0", irq); mismatches++; end
        compares++;
        regWrite(REG_EOI, 32'h0);
        #1;
        if (irq !== 1'b1 || irqId !== 3'd3) begin
            $display("[TB] FAIL coll_second_req: got irq=%0b id=%0d want irq=1 id=3", irq, irqId); mismatches++;
        end
        compares++;
        regWrite(REG_CTRL, 32'h0000_0001);
        regRead(REG_PEND, 1'b0, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL mode_change_clear: got %h want 0", rd); mismatches++; end
        compares++;
        regRead(REG_PEND, 1'b0, rd);
        if (rd !== 32'h08) begin $display("[TB] FAIL mode_level_follow: got %h want 8", rd); mismatches++; end
        compares++;
    endtask

    task automatic test_reset_midrun;
        regRead(REG_VEC, 1'b1, rd);
        if (rd !== 32'h8000_0003) begin $display("[TB] FAIL mid_vec: got %h want 80000003", rd); mismatches++; end
        compares++;
        #2 rst_n = 1'b0;
        #1;
        if (irq !== 1'b0 || irqId !== 3'd0) begin
            $display("[TB] FAIL mid_irq: got irq=%0b id=%0d want irq=0 id=0", irq, irqId); mismatches++;
        end
        compares++;
        regRead(REG_CTRL, 1'b0, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL mid_ctrl: got %h want 0", rd); mismatches++; end
        compares++;
        regRead(REG_MASK, 1'b0, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL mid_mask: got %h want 0", rd); mismatches++; end
        compares++;
        regRead(REG_PEND, 1'b0, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL mid_pend: got %h want 0", rd); mismatches++; end
        compares++;
        regRead(REG_INSV, 1'b0, rd);
        if (rd !== 32'h0) begin $display("[TB] FAIL mid_insv: got %h want 0", rd); mismatches++; end
        compares++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Scenario sequence
    initial begin
        compares   = 0;
        mismatches = 0;
        rst_n      = 1'b0;
        srcIrq     = '0;
        bus.we     = 1'b0;
        bus.rd_en  = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        test_reset();
        test_edge_basic();
        test_nesting();
        test_mask_gating();
        test_eoi_reserved();
        test_edge_collisions();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
